bank_allocator: RTL and testbench

//  Parametrised successor to bank_manager: N-bank polyphonic voice allocator with mixer.

---
 rtl/bank_allocator_if.sv | 30 +++
 rtl/bank_allocator.sv | 178 +++++++++++++++++
 tb/tb_bank_allocator.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/bank_allocator_if.sv
// Command, sample and voice-state bundle between a note source and bank_allocator.
// The master drives commands and samples; the slave drives the per-bank voice state.
interface bank_allocator_if #(
  parameter int N_BANKS  = 8,
  parameter int SAMPLE_W = 16
);
  localparam int CNT_W = $clog2(N_BANKS + 1);

  logic                          i_valid;
  logic [15:0]                   i_data;
  logic [N_BANKS*SAMPLE_W-1:0]   i_samples;
  logic [N_BANKS-1:0]            o_gate;
  logic [N_BANKS*7-1:0]          o_notes;
  logic [N_BANKS*8-1:0]          o_vel;
  logic [N_BANKS-1:0]            o_trig;
  logic [CNT_W-1:0]              o_active_cnt;
  logic                          o_steal;
  logic                          o_drop;
  logic [SAMPLE_W-1:0]           o_signal;

  modport master (
    output i_valid, i_data, i_samples,
    input  o_gate, o_notes, o_vel, o_trig, o_active_cnt, o_steal, o_drop, o_signal
  );

  modport slave (
    input  i_valid, i_data, i_samples,
    output o_gate, o_notes, o_vel, o_trig, o_active_cnt, o_steal, o_drop, o_signal
  );
endinterface

// File: rtl/bank_allocator.sv
// N-bank polyphonic voice allocator: decodes note commands, assigns/steals banks,
// tracks per-bank age and mixes the gated oscillator samples into one saturated output.
module bank_allocator #(
  parameter int N_BANKS  = 8,
  parameter int AGE_W    = 12,
  parameter int STEAL_EN = 1,
  parameter int SAMPLE_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  bank_allocator_if.slave  bus
);
  localparam int CNT_W = $clog2(N_BANKS + 1);
  localparam int IDX_W = $clog2(N_BANKS);
  localparam int SUM_W = SAMPLE_W + $clog2(N_BANKS);
  localparam logic [AGE_W-1:0] AGE_MAX = '1;
  localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  logic [N_BANKS-1:0]   gate_q, gate_d, trig_q, trig_d, hit;
  logic [6:0]           note_q [N_BANKS];
  logic [6:0]           note_d [N_BANKS];
  logic [7:0]           vel_q  [N_BANKS];
  logic [7:0]           vel_d  [N_BANKS];
  logic [AGE_W-1:0]     age_q  [N_BANKS];
  logic [AGE_W-1:0]     age_d  [N_BANKS];
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 steal_q, steal_d, drop_q, drop_d;
  logic [SAMPLE_W-1:0]  signal_q, signal_d;

  logic                 cmd_on;
  logic [6:0]           cmd_note;
  logic [7:0]           cmd_vel;
  logic                 hit_any, free_any, load;
  logic [IDX_W-1:0]     hit_idx, free_idx, old_idx, load_idx;
  logic [AGE_W-1:0]     old_age;
  logic signed [SUM_W-1:0]    sum;
  logic signed [SAMPLE_W-1:0] smp;

  assign cmd_on   = bus.i_data[15];
  assign cmd_note = bus.i_data[14:8];
  assign cmd_vel  = bus.i_data[7:0];

  for (genvar gi = 0; gi < N_BANKS; gi++) begin : g_bank
    assign hit[gi] = gate_q[gi] && (note_q[gi] == cmd_note);
    assign bus.o_notes[gi*7 +: 7] = note_q[gi];
    assign bus.o_vel[gi*8 +: 8]   = vel_q[gi];
  end

  assign bus.o_gate       = gate_q;
  assign bus.o_trig       = trig_q;
  assign bus.o_active_cnt = cnt_q;
  assign bus.o_steal      = steal_q;
  assign bus.o_drop       = drop_q;
  assign bus.o_signal     = signal_q;

  // Lowest-index hit/free bank; oldest bank with ties resolved toward lower index.
  always_comb begin
    hit_any  = 1'b0;
    hit_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    old_idx  = '0;
    old_age  = age_q[0];
    for (int k = N_BANKS - 1; k >= 0; k--) begin
      if (hit[k]) begin
        hit_any = 1'b1;
        hit_idx = IDX_W'(k);
      end
      if (!gate_q[k]) begin
        free_any = 1'b1;
        free_idx = IDX_W'(k);
      end
    end
    for (int k = 1; k < N_BANKS; k++) begin
      if (age_q[k] > old_age) begin
        old_age = age_q[k];
        old_idx = IDX_W'(k);
      end
    end
  end

  always_comb begin
    gate_d   = gate_q;
    note_d   = note_q;
    vel_d    = vel_q;
    trig_d   = '0;
    steal_d  = 1'b0;
    drop_d   = 1'b0;
    load     = 1'b0;
    load_idx = '0;
    if (bus.i_valid) begin
      if (!cmd_on && cmd_note == 7'd127) begin
        gate_d = '0;
      end else if (cmd_on && cmd_note == 7'd127) begin
        gate_d = gate_q;
      end else if (cmd_on && cmd_vel != 8'd0) begin
        if (hit_any) begin
          load     = 1'b1;
          load_idx = hit_idx;
        end else if (free_any) begin
          load     = 1'b1;
          load_idx = free_idx;
        end else if (STEAL_EN != 0) begin
          load     = 1'b1;
          load_idx = old_idx;
          steal_d  = 1'b1;
        end else begin
          drop_d = 1'b1;
        end
      end else if (hit_any) begin
        gate_d[hit_idx] = 1'b0;
      end
    end
    if (load) begin
      gate_d[load_idx] = 1'b1;
      note_d[load_idx] = cmd_note;
      vel_d[load_idx]  = cmd_vel;
      trig_d[load_idx] = 1'b1;
    end
    // Ages follow the next gate state so freed banks drop to zero on the same edge.
    cnt_d = '0;
    for (int k = 0; k < N_BANKS; k++) begin
      cnt_d = cnt_d + CNT_W'(gate_d[k]);
      if (!gate_d[k] || (load && load_idx == IDX_W'(k))) begin
        age_d[k] = '0;
      end else if (age_q[k] != AGE_MAX) begin
        age_d[k] = age_q[k] + 1'b1;
      end else begin
        age_d[k] = age_q[k];
      end
    end
  end

  always_comb begin
    sum = '0;
    smp = '0;
    for (int k = 0; k < N_BANKS; k++) begin
      smp = bus.i_samples[k*SAMPLE_W +: SAMPLE_W];
      if (gate_q[k]) begin
        sum = sum + {{(SUM_W-SAMPLE_W){smp[SAMPLE_W-1]}}, smp};
      end
    end
    if (sum > SAT_MAX) begin
      signal_d = SAT_MAX[SAMPLE_W-1:0];
    end else if (sum < SAT_MIN) begin
      signal_d = SAT_MIN[SAMPLE_W-1:0];
    end else begin
      signal_d = sum[SAMPLE_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gate_q   <= '0;
      trig_q   <= '0;
      cnt_q    <= '0;
      steal_q  <= 1'b0;
      drop_q   <= 1'b0;
      signal_q <= '0;
      for (int k = 0; k < N_BANKS; k++) begin
        note_q[k] <= '0;
        vel_q[k]  <= '0;
        age_q[k]  <= '0;
      end
    end else begin
      gate_q   <= gate_d;
      trig_q   <= trig_d;
      cnt_q    <= cnt_d;
      steal_q  <= steal_d;
      drop_q   <= drop_d;
      signal_q <= signal_d;
      note_q   <= note_d;
      vel_q    <= vel_d;
      age_q    <= age_d;
    end
  end
endmodule

// File: tb/tb_bank_allocator.sv
// Directed bench for bank_allocator: a vector table for command decode plus
// hand sequences for drop mode, mixer saturation and reset behaviour.
module tb_bank_allocator;
  logic clk = 1'b0;
  logic reset_a, reset_b;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  bank_allocator_if #(.N_BANKS(8), .SAMPLE_W(16)) ifa ();
  bank_allocator_if #(.N_BANKS(8), .SAMPLE_W(16)) ifb ();

  bank_allocator #(.N_BANKS(8), .AGE_W(12), .STEAL_EN(1), .SAMPLE_W(16)) dut_a (
    .clk(clk), .reset(reset_a), .bus(ifa.slave)
  );
  bank_allocator #(.N_BANKS(8), .AGE_W(12), .STEAL_EN(0), .SAMPLE_W(16)) dut_b (
    .clk(clk), .reset(reset_b), .bus(ifb.slave)
  );

  typedef struct {
    logic        valid;
    logic [15:0] data;
    logic [7:0]  gate;
    logic [7:0]  trig;
    logic [3:0]  cnt;
    logic        steal;
    logic        drop;
    int          bank;
    logic [6:0]  note;
    logic [7:0]  vel;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic v, logic [15:0] d, logic [7:0] g, logic [7:0] t, logic [3:0] c,
                              logic s, logic dr, int b, logic [6:0] n, logic [7:0] ve);
    vec_t r;
    r.valid = v; r.data = d; r.gate = g; r.trig = t; r.cnt = c;
    r.steal = s; r.drop = dr; r.bank = b; r.note = n; r.vel = ve;
    vecs.push_back(r);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [15:0] d);
    ifa.i_valid = v;
    ifa.i_data  = d;
  endtask

  task automatic drive_b(input logic v, input logic [15:0] d);
    ifb.i_valid = v;
    ifb.i_data  = d;
  endtask

  task automatic set_samples(input logic [15:0] s0, input logic [15:0] s1, input logic [15:0] s2);
    ifa.i_samples = '0;
    ifa.i_samples[0 +: 16]  = s0;
    ifa.i_samples[16 +: 16] = s1;
    ifa.i_samples[32 +: 16] = s2;
  endtask

  initial begin
    logic [15:0] d;
    logic [7:0]  g;
    reset_a = 1'b1;
    reset_b = 1'b1;
    drive_a(1'b0, 16'h0);
    drive_b(1'b0, 16'h0);
    ifa.i_samples = '0;
    ifb.i_samples = '0;
    step();
    step();
    chk("rst_gate",   32'(ifa.o_gate), 32'h0);
    chk("rst_notes",  32'(ifa.o_notes[31:0]), 32'h0);
    chk("rst_vel",    32'(ifa.o_vel[31:0]), 32'h0);
    chk("rst_cnt",    32'(ifa.o_active_cnt), 32'h0);
    chk("rst_pulses", {29'h0, ifa.o_steal, ifa.o_drop, |ifa.o_trig}, 32'h0);
    chk("rst_signal", 32'(ifa.o_signal), 32'h0);
    reset_a = 1'b0;
    reset_b = 1'b0;

    // Single note on/off, then four notes and a retrigger (note 10 = 0x0A).
    add(1, 16'h8A40, 8'h01, 8'h01, 1, 0, 0, 0, 7'd10, 8'h40);
    add(0, 16'h0000, 8'h01, 8'h00, 1, 0, 0, 0, 7'd10, 8'h40);
    add(0, 16'h0000, 8'h01, 8'h00, 1, 0, 0, 0, 7'd10, 8'h40);
    add(1, 16'h0A00, 8'h00, 8'h00, 0, 0, 0, 0, 7'd10, 8'h40);
    add(1, 16'hA850, 8'h01, 8'h01, 1, 0, 0, 0, 7'd40, 8'h50);
    add(1, 16'hBC50, 8'h03, 8'h02, 2, 0, 0, 1, 7'd60, 8'h50);
    add(1, 16'hCD50, 8'h07, 8'h04, 3, 0, 0, 2, 7'd77, 8'h50);
    add(1, 16'hDF50, 8'h0F, 8'h08, 4, 0, 0, 3, 7'd95, 8'h50);
    add(1, 16'hBC7F, 8'h0F, 8'h02, 4, 0, 0, 1, 7'd60, 8'h7F);
    add(1, 16'h0A00, 8'h0F, 8'h00, 4, 0, 0, 1, 7'd60, 8'h7F);
    add(0, 16'h8A40, 8'h0F, 8'h00, 4, 0, 0, 0, 7'd40, 8'h50);
    add(1, 16'h7F00, 8'h00, 8'h00, 0, 0, 0, 1, 7'd60, 8'h7F);
    for (int i = 1; i <= 8; i++) begin
      d = 16'h8010 | 16'(i << 8);
      g = 8'((9'd1 << i) - 9'd1);
      add(1, d, g, 8'(1 << (i - 1)), 4'(i), 0, 0, i - 1, 7'(i), 8'h10);
    end
    for (int i = 0; i < 5; i++) add(0, 16'h0000, 8'hFF, 8'h00, 8, 0, 0, 7, 7'd8, 8'h10);
    add(1, 16'hE220, 8'hFF, 8'h01, 8, 1, 0, 0, 7'd98, 8'h20);
    add(0, 16'h0000, 8'hFF, 8'h00, 8, 0, 0, 0, 7'd98, 8'h20);
    add(1, 16'hE320, 8'hFF, 8'h02, 8, 1, 0, 1, 7'd99, 8'h20);
    add(1, 16'hE230, 8'hFF, 8'h01, 8, 0, 0, 0, 7'd98, 8'h30);
    add(1, 16'h8300, 8'hFB, 8'h00, 7, 0, 0, 2, 7'd3,  8'h10);
    add(1, 16'hFF40, 8'hFB, 8'h00, 7, 0, 0, 2, 7'd3,  8'h10);
    add(1, 16'hB240, 8'hFF, 8'h04, 8, 0, 0, 2, 7'd50, 8'h40);
    add(1, 16'hE240, 8'hFF, 8'h01, 8, 0, 0, 0, 7'd98, 8'h40);

    foreach (vecs[i]) begin
      drive_a(vecs[i].valid, vecs[i].data);
      step();
      chk($sformatf("v%0d_gate", i),  32'(ifa.o_gate), 32'(vecs[i].gate));
      chk($sformatf("v%0d_trig", i),  32'(ifa.o_trig), 32'(vecs[i].trig));
      chk($sformatf("v%0d_cnt", i),   32'(ifa.o_active_cnt), 32'(vecs[i].cnt));
      chk($sformatf("v%0d_steal", i), 32'(ifa.o_steal), 32'(vecs[i].steal));
      chk($sformatf("v%0d_drop", i),  32'(ifa.o_drop), 32'(vecs[i].drop));
      chk($sformatf("v%0d_note", i),  32'(ifa.o_notes[vecs[i].bank*7 +: 7]), 32'(vecs[i].note));
      chk($sformatf("v%0d_vel", i),   32'(ifa.o_vel[vecs[i].bank*8 +: 8]), 32'(vecs[i].vel));
    end
    drive_a(1'b0, 16'h0);

    // Drop mode: full banks with stealing disabled leave state untouched.
    for (int i = 1; i <= 8; i++) begin
      drive_b(1'b1, 16'h8010 | 16'(i << 8));
      step();
    end
    drive_b(1'b0, 16'h0);
    for (int i = 0; i < 5; i++) step();
    drive_b(1'b1, 16'hE220);
    step();
    chk("b_drop",   32'(ifb.o_drop), 32'h1);
    chk("b_gate",   32'(ifb.o_gate), 32'hFF);
    chk("b_trig",   32'(ifb.o_trig), 32'h0);
    chk("b_steal",  32'(ifb.o_steal), 32'h0);
    chk("b_note0",  32'(ifb.o_notes[6:0]), 32'd1);
    drive_b(1'b0, 16'h0);
    step();
    chk("b_drop_end", 32'(ifb.o_drop), 32'h0);

    // Mixer: banks 0,1 gated, bank 2 free.
    drive_a(1'b1, 16'h7F00);
    step();
    drive_a(1'b1, 16'h8140);
    step();
    drive_a(1'b1, 16'h8240);
    step();
    drive_a(1'b0, 16'h0);
    chk("mix_gate", 32'(ifa.o_gate), 32'h03);
    set_samples(16'h7000, 16'h7000, 16'h7FFF);
    step();
    chk("mix_pos_sat", 32'(ifa.o_signal), 32'h7FFF);
    set_samples(16'h9000, 16'h9000, 16'h7FFF);
    step();
    chk("mix_neg_sat", 32'(ifa.o_signal), 32'h8000);
    set_samples(16'h1000, 16'h0100, 16'h7FFF);
    step();
    chk("mix_sum", 32'(ifa.o_signal), 32'h1100);
    drive_a(1'b1, 16'h7F00);
    step();
    drive_a(1'b0, 16'h0);
    step();
    chk("mix_nogate", 32'(ifa.o_signal), 32'h0);

    // Reset with three banks playing and a command in the same cycle.
    drive_a(1'b1, 16'h8140);
    step();
    drive_a(1'b1, 16'h8240);
    step();
    drive_a(1'b1, 16'h8340);
    step();
    chk("pre_rst_cnt", 32'(ifa.o_active_cnt), 32'd3);
    reset_a = 1'b1;
    drive_a(1'b1, 16'h8A40);
    step();
    chk("rst2_gate",   32'(ifa.o_gate), 32'h0);
    chk("rst2_cnt",    32'(ifa.o_active_cnt), 32'h0);
    chk("rst2_notes",  32'(ifa.o_notes[31:0]), 32'h0);
    chk("rst2_trig",   32'(ifa.o_trig), 32'h0);
    chk("rst2_signal", 32'(ifa.o_signal), 32'h0);
    reset_a = 1'b0;
    drive_a(1'b0, 16'h0);
    step();
    chk("post_rst_gate", 32'(ifa.o_gate), 32'h0);
    chk("post_rst_trig", 32'(ifa.o_trig), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
